// File: rtl/pix_frame_rcv.sv
// Framed UART pixel receiver: HEADER, LEN_H, LEN_L, N packed pixels, XOR checksum.
// Pixels are emitted while they arrive; the frame outcome is signalled with ACK/NAK.
module pix_frame_rcv #(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned PIX_WIDTH  = 12,
  parameter int unsigned MAX_PIX    = 4096,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter logic [7:0]  ACK_CODE   = 8'h06,
  parameter logic [7:0]  NAK_CODE   = 8'h15
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic [PIX_WIDTH-1:0]  o_pix,
  output logic [ADDR_WIDTH-1:0] o_pix_addr,
  output logic                  o_pix_valid,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_busy,
  output logic [7:0]            o_err_cnt
);

  localparam int unsigned BPP   = (PIX_WIDTH + 7) / 8;
  localparam int unsigned AW    = BPP * 8;
  localparam int unsigned LIMIT = CLK_FRE * TIMEOUT_US;
  localparam int unsigned TW    = $clog2(LIMIT + 1);
  localparam int unsigned BW    = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHK, S_REPLY
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          len_q;
  logic [15:0]          pix_idx_q;
  logic [BW-1:0]        byte_cnt_q;
  logic [AW-1:0]        asm_q;
  logic [7:0]           chk_q;
  logic                 ack_q;
  logic                 tmo_q;
  logic [TW-1:0]        tmo_cnt_q;
  logic [PIX_WIDTH-1:0] pix_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                 pv_q;
  logic [7:0]           err_cnt_q;

  logic [AW+7:0] asm_cat;
  logic [AW-1:0] asm_nx;
  logic [15:0]   len_n;
  logic          len_bad, byte_last, pix_last, active, tmo_hit;
  logic          unused_bits;

  assign asm_cat     = {asm_q, i_rx_data};
  assign asm_nx      = asm_cat[AW-1:0];
  assign unused_bits = ^asm_cat;
  assign len_n       = {len_q[15:8], i_rx_data};
  assign len_bad     = (len_n == 16'd0) || (32'(len_n) > MAX_PIX);
  assign byte_last   = (byte_cnt_q == BW'(BPP - 1));
  assign pix_last    = (pix_idx_q == len_q - 16'd1);
  assign active      = (state_q != S_IDLE) && (state_q != S_REPLY);
  // A byte arriving on the last timeout cycle still counts as in time.
  assign tmo_hit     = active && !i_rx_done && (tmo_cnt_q == TW'(LIMIT - 1));

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (i_rx_done && i_rx_data == HEADER) state_d = S_LEN_H;
      S_LEN_H:   if (i_rx_done) state_d = S_LEN_L;
      S_LEN_L:   if (i_rx_done) state_d = len_bad ? S_REPLY : S_PAYLOAD;
      S_PAYLOAD: if (i_rx_done && byte_last && pix_last) state_d = S_CHK;
      S_CHK:     if (i_rx_done) state_d = S_REPLY;
      S_REPLY:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  always_comb begin
    o_busy       = (state_q != S_IDLE);
    o_tx_valid   = (state_q == S_REPLY);
    o_tx_data    = '0;
    o_frame_done = 1'b0;
    o_frame_err  = tmo_q;
    if (state_q == S_REPLY) begin
      o_tx_data    = ack_q ? ACK_CODE : NAK_CODE;
      o_frame_done = ack_q;
      o_frame_err  = !ack_q;
    end
  end

  assign o_pix       = pix_q;
  assign o_pix_addr  = addr_q;
  assign o_pix_valid = pv_q;
  assign o_err_cnt   = err_cnt_q;

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      len_q      <= '0;
      pix_idx_q  <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      chk_q      <= '0;
      ack_q      <= 1'b0;
      tmo_q      <= 1'b0;
      tmo_cnt_q  <= '0;
      pix_q      <= '0;
      addr_q     <= '0;
      pv_q       <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      pv_q  <= 1'b0;
      tmo_q <= tmo_hit;
      if (i_rx_done || !active) tmo_cnt_q <= '0;
      else                      tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (o_frame_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (i_rx_done) begin
        unique case (state_q)
          S_IDLE: begin
            chk_q      <= '0;
            pix_idx_q  <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
          end
          S_LEN_H: begin
            len_q[15:8] <= i_rx_data;
            chk_q       <= chk_q ^ i_rx_data;
          end
          S_LEN_L: begin
            len_q[7:0] <= i_rx_data;
            chk_q      <= chk_q ^ i_rx_data;
            ack_q      <= 1'b0;
          end
          S_PAYLOAD: begin
            chk_q <= chk_q ^ i_rx_data;
            asm_q <= asm_nx;
            if (byte_last) begin
              pix_q      <= asm_nx[PIX_WIDTH-1:0];
              addr_q     <= pix_idx_q[ADDR_WIDTH-1:0];
              pv_q       <= 1'b1;
              pix_idx_q  <= pix_idx_q + 16'd1;
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
          S_CHK:   ack_q <= (i_rx_data == chk_q);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pix_frame_rcv.sv
// Directed bench: default 12-bit instance, 16-bit instance, and a small
// 8-bit instance (MAX_PIX=4, 40-cycle timeout) for boundary/timeout/reset cases.
module tb_pix_frame_rcv;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic [2:0] rxd;

  always #5 clk = ~clk;

  logic [11:0] pix_a; logic [11:0] addr_a;
  logic [15:0] pix_b; logic [11:0] addr_b;
  logic [7:0]  pix_c; logic [1:0]  addr_c;
  logic        pv_a, pv_b, pv_c, done_a, done_b, done_c, err_a, err_b, err_c;
  logic        txv_a, txv_b, txv_c, busy_a, busy_b, busy_c;
  logic [7:0]  txd_a, txd_b, txd_c, ec_a, ec_b, ec_c;

  pix_frame_rcv u_a (
    .i_clk_sys(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rxd[0]),
    .o_pix(pix_a), .o_pix_addr(addr_a), .o_pix_valid(pv_a), .o_frame_done(done_a),
    .o_frame_err(err_a), .o_tx_data(txd_a), .o_tx_valid(txv_a), .o_busy(busy_a),
    .o_err_cnt(ec_a));

  pix_frame_rcv #(.PIX_WIDTH(16)) u_b (
    .i_clk_sys(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rxd[1]),
    .o_pix(pix_b), .o_pix_addr(addr_b), .o_pix_valid(pv_b), .o_frame_done(done_b),
    .o_frame_err(err_b), .o_tx_data(txd_b), .o_tx_valid(txv_b), .o_busy(busy_b),
    .o_err_cnt(ec_b));

  pix_frame_rcv #(.CLK_FRE(1), .PIX_WIDTH(8), .MAX_PIX(4), .ADDR_WIDTH(2),
                  .TIMEOUT_US(40)) u_c (
    .i_clk_sys(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rxd[2]),
    .o_pix(pix_c), .o_pix_addr(addr_c), .o_pix_valid(pv_c), .o_frame_done(done_c),
    .o_frame_err(err_c), .o_tx_data(txd_c), .o_tx_valid(txv_c), .o_busy(busy_c),
    .o_err_cnt(ec_c));

  int checks = 0;
  int errors = 0;
  int npv = 0, ndone = 0, nerr = 0, ntx = 0;
  logic [7:0]  ltx = '0;
  logic [63:0] plog[$];
  logic [7:0]  seq[$];

  // Only one instance receives traffic at a time, so one event log suffices.
  always @(negedge clk) begin
    if (pv_a) plog.push_back({32'(addr_a), 32'(pix_a)});
    if (pv_b) plog.push_back({32'(addr_b), 32'(pix_b)});
    if (pv_c) plog.push_back({32'(addr_c), 32'(pix_c)});
    if (pv_a || pv_b || pv_c) npv = npv + 1;
    if (done_a || done_b || done_c) ndone = ndone + 1;
    if (err_a || err_b || err_c) nerr = nerr + 1;
    if (txv_a) begin ntx = ntx + 1; ltx = txd_a; end
    if (txv_b) begin ntx = ntx + 1; ltx = txd_b; end
    if (txv_c) begin ntx = ntx + 1; ltx = txd_c; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    npv = 0; ndone = 0; nerr = 0; ntx = 0; ltx = '0;
    plog.delete();
  endtask

  task automatic send_all(input int sel);
    foreach (seq[i]) begin
      @(negedge clk);
      rx_data  = seq[i];
      rxd[sel] = 1'b1;
      @(negedge clk);
      rxd = '0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic check_pix(input string tag, input logic [31:0] a, input logic [31:0] p);
    logic [63:0] e;
    e = (plog.size() > 0) ? plog.pop_front() : '1;
    check({tag, "_addr"}, e[63:32], a);
    check({tag, "_pix"}, e[31:0], p);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rxd = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'({busy_a, busy_b, busy_c}), 0);
    check("rst_errcnt", 32'(ec_a), 0);
    check("rst_pix", 32'(pix_a), 0);
    rst = 1'b0;

    // good 2-pixel frame, 12-bit pixels
    clr(); seq = '{8'hA5, 8'h00, 8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h96}; send_all(0);
    check("t1_npix", npv, 2);
    check_pix("t1_p0", 0, 32'hABC);
    check_pix("t1_p1", 1, 32'h123);
    check("t1_ntx", ntx, 1);
    check("t1_txd", 32'(ltx), 32'h06);
    check("t1_done", ndone, 1);
    check("t1_err", nerr, 0);
    check("t1_errcnt", 32'(ec_a), 0);
    check("t1_hold_pix", 32'(pix_a), 32'h123);

    // same frame, bad checksum
    clr(); seq = '{8'hA5, 8'h00, 8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h97}; send_all(0);
    check("t2_npix", npv, 2);
    check("t2_txd", 32'(ltx), 32'h15);
    check("t2_err", nerr, 1);
    check("t2_done", ndone, 0);
    check("t2_errcnt", 32'(ec_a), 1);

    // junk before header, zero length, then oversize length
    do_reset();
    clr(); seq = '{8'h3C, 8'hFF, 8'hA5, 8'h00, 8'h00}; send_all(0);
    check("t3_npix", npv, 0);
    check("t3_ntx", ntx, 1);
    check("t3_txd", 32'(ltx), 32'h15);
    check("t3_errcnt", 32'(ec_a), 1);
    check("t3_busy", 32'(busy_a), 0);
    clr(); seq = '{8'hA5, 8'h10, 8'h01}; send_all(0);
    check("t3b_ntx", ntx, 1);
    check("t3b_txd", 32'(ltx), 32'h15);
    check("t3b_errcnt", 32'(ec_a), 2);

    // 16-bit pixel; XOR 01^12^34 = 27 is good, 26 is bad
    clr(); seq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27}; send_all(1);
    check_pix("t5_p0", 0, 32'h1234);
    check("t5_txd", 32'(ltx), 32'h06);
    check("t5_done", ndone, 1);
    clr(); seq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26}; send_all(1);
    check("t5b_txd", 32'(ltx), 32'h15);
    check("t5b_errcnt", 32'(ec_b), 1);

    // reset in the middle of a 4-pixel payload
    clr(); seq = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22}; send_all(2);
    check("t6_busy_pre", 32'(busy_c), 1);
    do_reset();
    check("t6_busy_post", 32'(busy_c), 0);
    repeat (5) @(negedge clk);
    check("t6_ntx", ntx, 0);
    check("t6_err", nerr, 0);
    check("t6_errcnt", 32'(ec_c), 0);
    clr(); seq = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00}; send_all(2);
    check("t6b_npix", npv, 4);
    for (int i = 0; i < 4; i++) check_pix("t6b_p", 32'(i), 32'(i + 1));
    check("t6b_txd", 32'(ltx), 32'h06);
    check("t6b_done", ndone, 1);

    // MAX_PIX+1 rejected at LEN_L
    clr(); seq = '{8'hA5, 8'h00, 8'h05}; send_all(2);
    check("bnd_npix", npv, 0);
    check("bnd_txd", 32'(ltx), 32'h15);
    check("bnd_errcnt", 32'(ec_c), 1);

    // inter-byte timeout while waiting for CHK
    clr(); seq = '{8'hA5, 8'h00, 8'h01, 8'h0A}; send_all(2);
    repeat (30) @(negedge clk);
    check("t4_busy_wait", 32'(busy_c), 1);
    check("t4_err_early", nerr, 0);
    repeat (15) @(negedge clk);
    check("t4_err", nerr, 1);
    check("t4_ntx", ntx, 0);
    check("t4_busy", 32'(busy_c), 0);
    check("t4_errcnt", 32'(ec_c), 2);
    clr(); seq = '{8'hA5, 8'h00, 8'h01, 8'h0A, 8'h0B}; send_all(2);
    check_pix("t4b_p0", 0, 32'h0A);
    check("t4b_txd", 32'(ltx), 32'h06);
    check("t4b_done", ndone, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
